// File: rtl/hdmi_video_out.sv
// Purpose : 480p HDMI video back end; upscales a 160x144 shade framebuffer 3x into a centred window.
// Latency : every output (DE/HS/VS/D/frame_start) trails the raster counters by exactly 3 cycles.
// Backpressure: none; the raster is free-running and the framebuffer RAM is read every cycle.
//
// Ports:
//   HDMI_TX_CLK  pixel clock (only clock)      rst          async active-high reset
//   fb_addr      framebuffer read address      fb_data      shade index, one cycle after fb_addr
//   bgp          palette, latched per frame    lcd_en       0 = window shows white, latched per frame
//   HDMI_TX_DE/HS/VS/D  transmitter pins       frame_start  pulse with output pixel (0,0)
//
// SRC_W/SRC_H describe the source picture (160x144 on the real system); they are
// exposed so reduced rasters can be built around a smaller source.

module hdmi_video_out #(
  parameter int          H_ACTIVE   = 720,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 62,
  parameter int          H_BP       = 60,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 9,
  parameter int          V_SYNC     = 6,
  parameter int          V_BP       = 30,
  parameter int          WIN_X      = 120,
  parameter int          WIN_Y      = 24,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int          SRC_W      = 160,
  parameter int          SRC_H      = 144
) (
  input  logic        HDMI_TX_CLK,
  input  logic        rst,
  output logic [14:0] fb_addr,
  input  logic [1:0]  fb_data,
  input  logic [7:0]  bgp,
  input  logic        lcd_en,
  output logic        HDMI_TX_DE,
  output logic        HDMI_TX_HS,
  output logic        HDMI_TX_VS,
  output logic [23:0] HDMI_TX_D,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] WX_BEG  = 11'(WIN_X);
  localparam logic [10:0] WX_END  = 11'(WIN_X + 3 * SRC_W);
  localparam logic [10:0] WX_LAST = 11'(WIN_X + 3 * SRC_W - 1);

  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  WY_BEG  = 10'(WIN_Y);
  localparam logic [9:0]  WY_END  = 10'(WIN_Y + 3 * SRC_H);
  localparam logic [9:0]  WY_LAST = 10'(WIN_Y + 3 * SRC_H - 1);

  localparam logic [14:0] ROW_STEP = 15'(SRC_W);

  // Stage 0: raster counters and upscale sub-counters
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [1:0]  sub_x_q, sub_x_d;    // column repeat phase 0..2
  logic [7:0]  gx_q, gx_d;          // source column
  logic [1:0]  sub_y_q, sub_y_d;    // line repeat phase 0..2
  logic [14:0] row_base_q, row_base_d;  // gy*SRC_W, kept by accumulation

  // Stage 1: address and delayed raster flags
  logic [14:0] fb_addr_q, fb_addr_d;
  logic        s1_de_q, s1_de_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic        s1_win_q, s1_win_d;
  logic        s1_fs_q, s1_fs_d;

  // Stage 2: flags aligned with fb_data
  logic        s2_de_q, s2_de_d;
  logic        s2_hs_q, s2_hs_d;
  logic        s2_vs_q, s2_vs_d;
  logic        s2_win_q, s2_win_d;
  logic        s2_fs_q, s2_fs_d;

  // Per-frame captured controls
  logic [7:0]  pal_q, pal_d;
  logic        lcd_on_q, lcd_on_d;

  // Stage 3: registered outputs
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;

  logic        line_end;
  logic        frame_wrap;
  logic        x_win;
  logic        y_win;
  logic [1:0]  shade;
  logic [23:0] win_rgb;

  always_comb begin
    line_end   = (hcnt_q == H_LAST);
    frame_wrap = line_end && (vcnt_q == V_LAST);
    x_win      = (hcnt_q >= WX_BEG) && (hcnt_q < WX_END);
    y_win      = (vcnt_q >= WY_BEG) && (vcnt_q < WY_END);

    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end

    // Horizontal sub-counters describe the current column and sit at 0
    // outside the window, so the first window column always fetches gx=0.
    sub_x_d = sub_x_q;
    gx_d    = gx_q;
    if (x_win) begin
      if (hcnt_q == WX_LAST) begin
        sub_x_d = '0;
        gx_d    = '0;
      end else if (sub_x_q == 2'd2) begin
        sub_x_d = '0;
        gx_d    = gx_q + 8'd1;
      end else begin
        sub_x_d = sub_x_q + 2'd1;
      end
    end

    // Vertical sub-counters advance at the end of each window line.
    sub_y_d    = sub_y_q;
    row_base_d = row_base_q;
    if (line_end && y_win) begin
      if (vcnt_q == WY_LAST) begin
        sub_y_d    = '0;
        row_base_d = '0;
      end else if (sub_y_q == 2'd2) begin
        sub_y_d    = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        sub_y_d = sub_y_q + 2'd1;
      end
    end

    fb_addr_d = (x_win && y_win) ? (row_base_q + {7'd0, gx_q}) : 15'd0;
    s1_de_d   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    s1_hs_d   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    s1_vs_d   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    s1_win_d  = x_win && y_win;
    s1_fs_d   = (hcnt_q == 11'd0) && (vcnt_q == 10'd0);

    s2_de_d  = s1_de_q;
    s2_hs_d  = s1_hs_q;
    s2_vs_d  = s1_vs_q;
    s2_win_d = s1_win_q;
    s2_fs_d  = s1_fs_q;

    // Palette and enable only change at the raster wrap; the last lines of a
    // frame are blanking, so no visible pixel sees a mixed setting.
    pal_d    = frame_wrap ? bgp : pal_q;
    lcd_on_d = frame_wrap ? lcd_en : lcd_on_q;
  end

  always_comb begin
    case (fb_data)
      2'd0:    shade = pal_q[1:0];
      2'd1:    shade = pal_q[3:2];
      2'd2:    shade = pal_q[5:4];
      default: shade = pal_q[7:6];
    endcase
    case (shade)
      2'd0:    win_rgb = 24'hFFFFFF;
      2'd1:    win_rgb = 24'hAAAAAA;
      2'd2:    win_rgb = 24'h555555;
      default: win_rgb = 24'h000000;
    endcase

    rgb_d = 24'h000000;
    if (s2_de_q) begin
      if (!s2_win_q)      rgb_d = BORDER_RGB;
      else if (!lcd_on_q) rgb_d = 24'hFFFFFF;
      else                rgb_d = win_rgb;
    end
    de_d = s2_de_q;
    hs_d = s2_hs_q;
    vs_d = s2_vs_q;
    fs_d = s2_fs_q;
  end

  always_ff @(posedge HDMI_TX_CLK or posedge rst) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      sub_x_q    <= '0;
      gx_q       <= '0;
      sub_y_q    <= '0;
      row_base_q <= '0;
      fb_addr_q  <= '0;
      s1_de_q    <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_win_q   <= 1'b0;
      s1_fs_q    <= 1'b0;
      s2_de_q    <= 1'b0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_win_q   <= 1'b0;
      s2_fs_q    <= 1'b0;
      pal_q      <= 8'hE4;
      lcd_on_q   <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      sub_x_q    <= sub_x_d;
      gx_q       <= gx_d;
      sub_y_q    <= sub_y_d;
      row_base_q <= row_base_d;
      fb_addr_q  <= fb_addr_d;
      s1_de_q    <= s1_de_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_win_q   <= s1_win_d;
      s1_fs_q    <= s1_fs_d;
      s2_de_q    <= s2_de_d;
      s2_hs_q    <= s2_hs_d;
      s2_vs_q    <= s2_vs_d;
      s2_win_q   <= s2_win_d;
      s2_fs_q    <= s2_fs_d;
      pal_q      <= pal_d;
      lcd_on_q   <= lcd_on_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign HDMI_TX_DE  = de_q;
  assign HDMI_TX_HS  = hs_q;
  assign HDMI_TX_VS  = vs_q;
  assign HDMI_TX_D   = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_out.sv
// Bench for hdmi_video_out on a reduced raster (56x39 total, 10x8 source
// upscaled into a 30x24 window) so many frames fit in a short run.
module tb_hdmi_video_out;

  localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSW = 3, VBP = 4;
  localparam int WX = 5, WY = 3, SW = 10, SH = 8;
  localparam logic [23:0] BORDER = 24'h123456;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data = 2'd0;
  logic [7:0]  bgp = 8'hE4;
  logic        lcd_en = 1'b1;
  logic        de, hs, vs, fs;
  logic [23:0] d;

  hdmi_video_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .WIN_X(WX), .WIN_Y(WY), .BORDER_RGB(BORDER), .SRC_W(SW), .SRC_H(SH)
  ) dut (
    .HDMI_TX_CLK(clk), .rst(rst), .fb_addr(fb_addr), .fb_data(fb_data),
    .bgp(bgp), .lcd_en(lcd_en), .HDMI_TX_DE(de), .HDMI_TX_HS(hs),
    .HDMI_TX_VS(vs), .HDMI_TX_D(d), .frame_start(fs)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer RAM with random shade contents
  logic [1:0] mem [0:32767];
  always @(posedge clk) fb_data <= mem[fb_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;   // absolute rising-edge count
  int k = 0;     // rising edges since reset release

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: palette / enable in force for each frame since reset
  logic [7:0] fpal [16];
  logic       flcd [16];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      k = 0;
      fpal[0] = 8'hE4;
      flcd[0] = 1'b0;
    end else begin
      k++;
      if (k % FT == 0) begin
        fpal[(k / FT) % 16] = bgp;
        flcd[(k / FT) % 16] = lcd_en;
      end
    end
  end

  function automatic bit in_win(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    return (h >= WX) && (h < WX + 3 * SW) && (v >= WY) && (v < WY + 3 * SH);
  endfunction

  function automatic int exp_addr(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    if (!in_win(p)) return 0;
    return ((v - WY) / 3) * SW + (h - WX) / 3;
  endfunction

  function automatic logic [23:0] exp_rgb(input int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    int f = (p / FT) % 16;
    int idx, sh, lvl;
    logic [7:0] l8;
    if (!(h < HA && v < VA)) return 24'h000000;
    if (!in_win(p)) return BORDER;
    if (!flcd[f]) return 24'hFFFFFF;
    idx = int'(mem[exp_addr(p)]);
    sh  = (int'(fpal[f]) >> (2 * idx)) & 3;
    lvl = 255 - 85 * sh;
    l8  = 8'(lvl);
    return {l8, l8, l8};
  endfunction

  // Per-cycle comparison against the model plus measured timing checks
  int  p;
  logic prev_de = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  int  run_len = 0, de_frame_cnt = 0;
  bit  frame_valid = 0, fs_seen = 0, vs_seen = 0, de_fall_seen = 0;
  int  last_fs = 0, last_vs = 0, last_de_fall = 0, hs_fall = 0;

  always @(negedge clk) begin
    if (rst || k < 3) begin
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_hs", 32'(hs), 32'd1);
      chk("rst_vs", 32'(vs), 32'd1);
      chk("rst_d",  32'(d),  32'd0);
      chk("rst_fs", 32'(fs), 32'd0);
    end else begin
      p = k - 3;
      chk("de", 32'(de), 32'((p % HT < HA) && ((p / HT) % VT < VA)));
      chk("hs", 32'(hs), 32'(!((p % HT >= HA + HFP) && (p % HT < HA + HFP + HSW))));
      chk("vs", 32'(vs), 32'(!(((p / HT) % VT >= VA + VFP) && ((p / HT) % VT < VA + VFP + VSW))));
      chk("fs", 32'(fs), 32'(p % FT == 0));
      chk("rgb", 32'(d), 32'(exp_rgb(p)));
    end
    if (rst || k < 1) chk("addr_idle", 32'(fb_addr), 32'd0);
    else              chk("addr", 32'(fb_addr), 32'(exp_addr(k - 1)));

    if (rst) begin
      prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
      run_len = 0; de_frame_cnt = 0;
      frame_valid = 0; fs_seen = 0; vs_seen = 0; de_fall_seen = 0;
    end else begin
      if (fs) begin
        chk("fs_de_rise", 32'({prev_de, de}), 32'b01);
        if (frame_valid) chk("de_per_frame", 32'(de_frame_cnt), 32'(HA * VA));
        de_frame_cnt = 0;
        frame_valid  = 1;
        last_fs      = cyc;
        fs_seen      = 1;
      end
      if (de) begin
        run_len++;
        de_frame_cnt++;
      end
      if (prev_de && !de) begin
        chk("de_burst", 32'(run_len), 32'(HA));
        run_len = 0;
        last_de_fall = cyc;
        de_fall_seen = 1;
      end
      if (prev_hs && !hs) begin
        hs_fall = cyc;
        if (de_fall_seen && (cyc - last_de_fall) < HT)
          chk("hs_after_de", 32'(cyc - last_de_fall), 32'(HFP));
      end
      if (!prev_hs && hs && hs_fall > 0) chk("hs_width", 32'(cyc - hs_fall), 32'(HSW));
      if (prev_vs && !vs) begin
        if (vs_seen) chk("vs_period", 32'(cyc - last_vs), 32'(FT));
        if (fs_seen) chk("fs_to_vs", 32'(cyc - last_fs), 32'((VA + VFP) * HT));
        last_vs = cyc;
        vs_seen = 1;
      end
      if (!prev_vs && vs && vs_seen) chk("vs_width", 32'(cyc - last_vs), 32'(VSW * HT));
      prev_de = de; prev_hs = hs; prev_vs = vs;
    end
  end

  // Advance until the model edge count reaches kk, then step off the edge
  task automatic run_to(input int kk);
    int n = 0;
    while (k < kk && n < 4 * FT) begin
      @(negedge clk);
      n++;
    end
    if (k < kk) chk("run_to_timeout", 32'(k), 32'(kk));
    #2;
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 2'($urandom_range(0, 3));
    rst = 1'b1; bgp = 8'hE4; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Frame 0 shows a white window (enable latched at reset); frame 1 uses E4.
    run_to(FT + FT / 2);
    bgp = 8'h1B;                         // takes effect in frame 2 only
    run_to(3 * FT - 100);
    lcd_en = 1'b0;                       // frame 3: white window
    bgp = 8'($urandom);
    run_to(3 * FT + FT / 2);
    lcd_en = 1'b1;
    bgp = 8'($urandom);

    // Mid-frame reset at counter position h=20, v=10 of frame 4
    run_to(4 * FT + 10 * HT + 20);
    rst = 1'b1;
    #1;
    chk("async_de", 32'(de), 32'd0);
    chk("async_hs", 32'(hs), 32'd1);
    chk("async_vs", 32'(vs), 32'd1);
    chk("async_d",  32'(d),  32'd0);
    chk("async_fs", 32'(fs), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    for (int f = 0; f < 4; f++) begin
      run_to(f * FT + int'($urandom_range(1, FT - 1)));
      bgp    = 8'($urandom);
      lcd_en = ($urandom_range(0, 3) != 0);
    end
    run_to(4 * FT + 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
